// File: rtl/syn_fifo_pkg.sv
// -----------------------------------------------------------------------------
// syn_fifo_pkg
//   Shared constants and helpers for the synchronous FIFO and its storage.
//   - DEF_WIDTH / DEF_DEPTH : default data width and entry count
//   - clog2()               : ceiling log2, used to size pointers and counters
// -----------------------------------------------------------------------------
package syn_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Ceiling log2 for elaboration-time sizing; clog2(16) = 4, clog2(17) = 5.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage : syn_fifo_pkg

// File: rtl/sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
//   Simple dual-port RAM, WIDTH x DEPTH: one synchronous write port and one
//   registered read port. Neither the array nor the read register is reset.
//   Ports:
//     clk      : clock, all activity on the rising edge
//     wr_en    : write enable
//     wr_addr  : write address
//     wr_data  : write data
//     rd_en    : read enable; rd_data holds its value when low
//     rd_addr  : read address
//     rd_data  : registered read data (1-cycle latency)
//   A read and a write to the same address in one cycle return the old word.
// -----------------------------------------------------------------------------
module sdp_ram
    import syn_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    input  logic [clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]          rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // NOTE: storage has no reset so it maps onto RAM macros/LUT-RAM; the FIFO
    // never exposes an entry that has not been written since reset.
    // NOTE: non-blocking assignments here give read-before-write on a shared
    // address and keep every clocked element race-free in simulation.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule : sdp_ram

// File: rtl/syn_fifo.sv
// -----------------------------------------------------------------------------
// syn_fifo
//   Single-clock FIFO with registered read data and registered status flags.
//   Ports:
//     clk          : clock, rising edge
//     reset        : asynchronous, active-high reset
//     write        : write request, data_in sampled with it
//     data_in      : write data
//     read         : read request
//     data_out     : read data, valid one cycle after an accepted read, held
//                    otherwise; 0 after reset until the first accepted read
//     full/empty   : occupancy == DEPTH / occupancy == 0
//     almost_full  : occupancy >= AF_LEVEL
//     almost_empty : occupancy <= AE_LEVEL
//     count        : occupancy, 0..DEPTH
//     overflow     : one-cycle pulse after a rejected write
//     underflow    : one-cycle pulse after a rejected read
//   A write into a full FIFO is accepted when a read is accepted in the same
//   cycle. A read of an empty FIFO is rejected even with a concurrent write.
// -----------------------------------------------------------------------------
module syn_fifo
    import syn_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    read,
    output logic [WIDTH-1:0]        data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             almost_full_q, almost_full_d;
    logic             almost_empty_q, almost_empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    // Set by the first accepted read after reset; until then data_out is
    // forced to 0 because the RAM read register itself is not reset.
    logic             out_valid_q, out_valid_d;

    logic             rd_ok;
    logic             wr_ok;
    logic [WIDTH-1:0] ram_rd_data;

    // Acceptance uses the registered flags only, so no output is ever a
    // combinational function of read/write.
    assign rd_ok = read & ~empty_q;
    assign wr_ok = write & (~full_q | rd_ok);

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;

        if (wr_ok) begin
            // DEPTH is a power of two, so natural overflow wraps to 0.
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            out_valid_d = 1'b1;
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Flags follow the next count so they are consistent with it after
        // the edge; full/empty come from the count, not pointer equality.
        full_d         = (count_d == CNT_W'(DEPTH));
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= CNT_W'(AF_LEVEL));
        almost_empty_d = (count_d <= CNT_W'(AE_LEVEL));
        overflow_d     = write & ~wr_ok;
        underflow_d    = read & empty_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            out_valid_q    <= out_valid_d;
        end
    end

    sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    assign data_out     = out_valid_q ? ram_rd_data : '0;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule : syn_fifo

// File: tb/tb_syn_fifo.sv
// -----------------------------------------------------------------------------
// tb_syn_fifo
//   Directed test of syn_fifo (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
//   followed by a short random phase against a queue reference.
// -----------------------------------------------------------------------------
module tb_syn_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic             clk;
    logic             reset;
    logic             write;
    logic [WIDTH-1:0] data_in;
    logic             read;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [4:0]       count;
    logic             overflow;
    logic             underflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] model_q [$];

    syn_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write        (write),
        .data_in      (data_in),
        .read         (read),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Occupancy and the four level flags expected for a given count.
    task automatic check_level(input string tag, input int cnt);
        check({tag, ".count"}, 32'(count), 32'(cnt));
        check({tag, ".full"}, 32'(full), 32'(cnt == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(cnt >= AF));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(cnt <= AE));
    endtask

    // One clock with the given requests; outputs sampled 1 time unit after
    // the rising edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        write   = w;
        data_in = d;
        read    = r;
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
    endtask

    initial begin
        write   = 1'b0;
        read    = 1'b0;
        data_in = '0;
        reset   = 1'b1;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check_level("reset", 0);
        check("reset.data_out", 32'(data_out), 32'h0);
        check("reset.overflow", 32'(overflow), 32'h0);
        check("reset.underflow", 32'(underflow), 32'h0);
        reset = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        check_level("idle", 0);

        // ---- fill 0x01..0x10 ----
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 8'(k), 1'b0);
            check_level($sformatf("fill%0d", k), k);
        end

        // ---- write while full: dropped, one-cycle overflow ----
        step(1'b1, 8'hAA, 1'b0);
        check("ovf.overflow", 32'(overflow), 32'h1);
        check_level("ovf", 16);
        step(1'b0, 8'h00, 1'b0);
        check("ovf_next.overflow", 32'(overflow), 32'h0);

        // ---- drain: 0x01..0x10 in order, 0xAA absent ----
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 8'h00, 1'b1);
            check($sformatf("drain%0d.data_out", k), 32'(data_out), 32'(k));
            check_level($sformatf("drain%0d", k), 16 - k);
        end
        step(1'b0, 8'h00, 1'b0);
        check("hold.data_out", 32'(data_out), 32'h10);

        // ---- read while empty with write: underflow, write accepted ----
        step(1'b1, 8'h55, 1'b1);
        check("unf.underflow", 32'(underflow), 32'h1);
        check("unf.data_out", 32'(data_out), 32'h10);
        check_level("unf", 1);
        step(1'b0, 8'h00, 1'b1);
        check("unf_next.underflow", 32'(underflow), 32'h0);
        check("unf_next.data_out", 32'(data_out), 32'h55);
        check_level("unf_next", 0);

        // ---- full FIFO, 20 cycles of simultaneous read/write ----
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 8'(k), 1'b0);
        end
        check_level("refill", 16);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 8'h77, 1'b1);
            check($sformatf("rw%0d.data_out", k), 32'(data_out),
                  (k < 16) ? 32'(k + 1) : 32'h77);
            check($sformatf("rw%0d.overflow", k), 32'(overflow), 32'h0);
            check_level($sformatf("rw%0d", k), 16);
        end
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 8'h00, 1'b1);
            check($sformatf("rwdrain%0d.data_out", k), 32'(data_out), 32'h77);
        end
        check_level("rwdrain", 0);

        // ---- reset mid-stream ----
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 8'hA0 + 8'(k), 1'b0);
        end
        check_level("pre_rst", 5);
        reset = 1'b1;
        #1;
        check_level("mid_rst", 0);
        check("mid_rst.data_out", 32'(data_out), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 8'h3C, 1'b0);
        check_level("post_rst_wr", 1);
        step(1'b0, 8'h00, 1'b1);
        check("post_rst_rd.data_out", 32'(data_out), 32'h3C);
        check_level("post_rst_rd", 0);

        // ---- random traffic against a queue reference ----
        model_q.delete();
        for (int c = 0; c < 600; c++) begin
            logic       w;
            logic       r;
            logic [7:0] d;
            logic       exp_rd_ok;
            logic       exp_wr_ok;
            logic       exp_ovf;
            logic       exp_unf;
            logic [7:0] exp_dout;
            int         wp;
            // Phases bias toward filling, then draining, then balanced.
            wp = (c < 200) ? 75 : ((c < 400) ? 25 : 50);
            w  = ($urandom_range(99) < 32'(wp));
            r  = ($urandom_range(99) < 32'(100 - wp));
            d  = 8'($urandom);
            exp_dout  = data_out;
            exp_rd_ok = r && (model_q.size() > 0);
            exp_wr_ok = w && ((model_q.size() < DEPTH) || exp_rd_ok);
            exp_ovf   = w && !exp_wr_ok;
            exp_unf   = r && (model_q.size() == 0);
            if (exp_rd_ok) exp_dout = model_q.pop_front();
            if (exp_wr_ok) model_q.push_back(d);
            step(w, d, r);
            check($sformatf("rnd%0d.data_out", c), 32'(data_out), 32'(exp_dout));
            check($sformatf("rnd%0d.overflow", c), 32'(overflow), 32'(exp_ovf));
            check($sformatf("rnd%0d.underflow", c), 32'(underflow), 32'(exp_unf));
            check_level($sformatf("rnd%0d", c), model_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_syn_fifo
